// File: rtl/line_mem_pkg.sv
// line_mem_pkg: shared widths and FSM state type
// for the line memory responder.
package line_mem_pkg;

  localparam int LINE_W   = 256;
  localparam int ADDR_W   = 32;
  localparam int OFFSET_W = 5;
  localparam int CNT_W    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/line_mem_array.sv
// line_mem_array: DEPTH x LINE_W storage with a
// synchronous write port and a registered read port.
module line_mem_array
  import line_mem_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [LINE_W-1:0] i_wdata,
  output logic [LINE_W-1:0] o_rdata
);

  logic [LINE_W-1:0] r_mem [DEPTH];
  logic [LINE_W-1:0] r_rdata;

  // line storage: cleared on reset, whole-line write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_idx] <= i_wdata;
    end
  end

  // read register: holds the last line read
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_idx];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/line_mem_responder.sv
// line_mem_responder: captures one line request,
// waits LATENCY cycles, then pulses resp.
module line_mem_responder
  import line_mem_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        rmask,
  input  logic [3:0]        wmask,
  input  logic [LINE_W-1:0] wdata,
  output logic [LINE_W-1:0] rdata,
  output logic              resp,
  output logic              err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_INIT =
    CNT_W'(LATENCY - 1);
  localparam logic LAT_ONE = (LATENCY == 1);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [IDX_W-1:0]  r_idx;
  logic [LINE_W-1:0] r_wdata;
  logic              r_wr;
  logic              r_rd;
  logic              r_resp;
  logic              r_err;

  logic              w_req_rd;
  logic              w_req_wr;
  logic              w_cap;
  logic              w_enter_resp;
  logic              w_op_wr;
  logic              w_op_rd;
  logic [IDX_W-1:0]  w_in_idx;
  logic [IDX_W-1:0]  w_idx;
  logic [LINE_W-1:0] w_wdata;
  logic              w_we;
  logic              w_re;
  logic              w_unused_addr;

  assign w_req_rd = |rmask;
  assign w_req_wr = |wmask;
  assign w_in_idx = addr[OFFSET_W +: IDX_W];

  assign w_cap =
    (r_state == IDLE) & (w_req_rd | w_req_wr);

  // with LATENCY=1 the capture edge is also the
  // edge entering RESP, so use live inputs then
  assign w_enter_resp =
    (w_cap & LAT_ONE) |
    ((r_state == BUSY) & (r_cnt == 1));

  assign w_op_wr = (r_state == IDLE) ?
    w_req_wr : r_wr;
  assign w_op_rd = (r_state == IDLE) ?
    (w_req_rd & ~w_req_wr) : r_rd;
  assign w_idx = (r_state == IDLE) ?
    w_in_idx : r_idx;
  assign w_wdata = (r_state == IDLE) ?
    wdata : r_wdata;

  assign w_we = w_enter_resp & w_op_wr;
  assign w_re = w_enter_resp & w_op_rd;

  assign w_unused_addr = &{
    1'b0,
    addr[OFFSET_W-1:0],
    addr[ADDR_W-1:OFFSET_W+IDX_W]
  };

  // request FSM with latency counter and outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_wr    <= 1'b0;
      r_rd    <= 1'b0;
      r_resp  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_resp <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_cap) begin
            r_idx   <= w_in_idx;
            r_wdata <= wdata;
            r_wr    <= w_req_wr;
            r_rd    <= w_req_rd & ~w_req_wr;
            if (w_req_rd & w_req_wr) begin
              r_err <= 1'b1;
            end
            if (LAT_ONE) begin
              r_state <= RESP;
              r_cnt   <= '0;
              r_resp  <= 1'b1;
            end else begin
              r_state <= BUSY;
              r_cnt   <= CNT_INIT;
            end
          end
        end
        BUSY: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == 1) begin
            r_state <= RESP;
            r_resp  <= 1'b1;
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  line_mem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_we),
    .i_re    (w_re),
    .i_idx   (w_idx),
    .i_wdata (w_wdata),
    .o_rdata (rdata)
  );

  assign resp = r_resp;
  assign err  = r_err;

endmodule

// File: tb/tb_line_mem_responder.sv
// tb_line_mem_responder: directed requests with a
// resp-driven scoreboard on LATENCY=4 and =1 instances.
module tb_line_mem_responder;

  typedef struct {
    int           cyc;
    logic [255:0] rd;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  logic [31:0]  addr0 = '0, addr1 = '0;
  logic [3:0]   rmask0 = '0, rmask1 = '0;
  logic [3:0]   wmask0 = '0, wmask1 = '0;
  logic [255:0] wdata0 = '0, wdata1 = '0;
  logic [255:0] rdata0, rdata1;
  logic         resp0, resp1;
  logic         err0, err1;

  exp_t q0[$];
  exp_t q1[$];

  localparam logic [255:0] L_A5 = {32{8'hA5}};
  localparam logic [255:0] L_5A = {32{8'h5A}};
  localparam logic [255:0] L_FF = {256{1'b1}};
  localparam logic [255:0] L_PT = {8{32'h0123_4567}};

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  line_mem_responder #(
    .DEPTH(16), .LATENCY(4)
  ) u_dut0 (
    .clk(clk), .rst(rst), .addr(addr0),
    .rmask(rmask0), .wmask(wmask0), .wdata(wdata0),
    .rdata(rdata0), .resp(resp0), .err(err0)
  );

  line_mem_responder #(
    .DEPTH(16), .LATENCY(1)
  ) u_dut1 (
    .clk(clk), .rst(rst), .addr(addr1),
    .rmask(rmask1), .wmask(wmask1), .wdata(wdata1),
    .rdata(rdata1), .resp(resp1), .err(err1)
  );

  task automatic chk(
    input string        nm,
    input logic [255:0] act,
    input logic [255:0] exp
  );
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic drive(
    input int           s,
    input logic [31:0]  a,
    input logic [3:0]   rm,
    input logic [3:0]   wm,
    input logic [255:0] wd
  );
    if (s == 0) begin
      addr0 = a; rmask0 = rm;
      wmask0 = wm; wdata0 = wd;
    end else begin
      addr1 = a; rmask1 = rm;
      wmask1 = wm; wdata1 = wd;
    end
  endtask

  // one-shot request; resp expected at capture+LAT-1
  task automatic issue(
    input int           s,
    input logic [31:0]  a,
    input logic [3:0]   rm,
    input logic [3:0]   wm,
    input logic [255:0] wd,
    input logic [255:0] exp_rd
  );
    int lat;
    int c0;
    lat = (s == 0) ? 4 : 1;
    @(negedge clk);
    drive(s, a, rm, wm, wd);
    c0 = cyc + 1;
    if (s == 0) q0.push_back('{c0 + lat - 1, exp_rd});
    else        q1.push_back('{c0 + lat - 1, exp_rd});
    @(negedge clk);
    drive(s, a, 4'h0, 4'h0, '0);
    repeat (lat + 1) @(negedge clk);
  endtask

  // monitors: every resp must match the queue head
  always @(negedge clk) begin
    if (resp0) begin
      if (q0.size() == 0) begin
        total++; bad++;
        $display("FAIL resp0_unexpected cyc=%0d", cyc);
      end else begin
        exp_t e;
        e = q0.pop_front();
        chk("resp0_cycle", 256'(cyc), 256'(e.cyc));
        chk("resp0_rdata", rdata0, e.rd);
      end
    end
  end

  always @(negedge clk) begin
    if (resp1) begin
      if (q1.size() == 0) begin
        total++; bad++;
        $display("FAIL resp1_unexpected cyc=%0d", cyc);
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("resp1_cycle", 256'(cyc), 256'(e.cyc));
        chk("resp1_rdata", rdata1, e.rd);
      end
    end
  end

  initial begin
    int c0;
    repeat (3) @(negedge clk);
    chk("rst_resp0", 256'(resp0), 256'(0));
    chk("rst_rdata0", rdata0, '0);
    chk("rst_err0", 256'(err0), 256'(0));
    chk("rst_rdata1", rdata1, '0);
    rst = 1'b1;

    issue(0, 32'h40, 4'h1, 4'h0, '0, '0);
    issue(0, 32'h60, 4'h0, 4'hF, L_A5, '0);
    issue(0, 32'h60, 4'h1, 4'h0, '0, L_A5);
    issue(0, 32'h80, 4'hF, 4'h0, '0, '0);

    // read held through resp: two pulses 5 apart
    @(negedge clk);
    drive(0, 32'h60, 4'h1, 4'h0, '0);
    c0 = cyc + 1;
    q0.push_back('{c0 + 3, L_A5});
    q0.push_back('{c0 + 8, L_A5});
    repeat (6) @(negedge clk);
    drive(0, 32'h0, 4'h0, 4'h0, '0);
    repeat (6) @(negedge clk);

    // both masks: write only, rdata unchanged
    issue(0, 32'h20, 4'hF, 4'hF, L_5A, L_A5);
    chk("err_set", 256'(err0), 256'(1));
    issue(0, 32'h20, 4'h2, 4'h0, '0, L_5A);
    chk("err_sticky", 256'(err0), 256'(1));

    // reset while a write is pending
    @(negedge clk);
    drive(0, 32'h20, 4'h0, 4'h1, L_FF);
    @(negedge clk);
    drive(0, 32'h0, 4'h0, 4'h0, '0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mid_err", 256'(err0), 256'(0));
    chk("rst_mid_rdata", rdata0, '0);
    chk("rst_mid_resp", 256'(resp0), 256'(0));
    @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    issue(0, 32'h20, 4'h1, 4'h0, '0, '0);
    chk("err_after_rst", 256'(err0), 256'(0));

    // LATENCY=1: 0x200 aliases index 0
    issue(1, 32'h200, 4'h0, 4'h1, L_PT, '0);
    issue(1, 32'h0, 4'h1, 4'h0, '0, L_PT);
    chk("err1_clear", 256'(err1), 256'(0));

    repeat (4) @(negedge clk);
    chk("q0_drained", 256'(q0.size()), 256'(0));
    chk("q1_drained", 256'(q1.size()), 256'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/line_mem_responder.md
LINE_MEM_RESPONDER -- requirements
Module: line_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning the number of 256-bit lines stored (power of two, 2..256).
REQ-002 SHALL have parameter LATENCY, default 4, meaning the number of cycles from request capture to resp (1..15).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port addr  input  32  line address; bits [4:0] ignored; index = addr[5 +: log2(DEPTH)]; upper bits ignored (aliasing).
REQ-006 SHALL have port rmask  input  4  read request when any bit is set.
REQ-007 SHALL have port wmask  input  4  write request when any bit is set (whole-line write).
REQ-008 SHALL have port wdata  input  256  line write data.
REQ-009 SHALL have port rdata  output  256  line read data, registered.
REQ-010 SHALL have port resp  output  1  one-cycle completion pulse, registered.
REQ-011 SHALL have port err  output  1  sticky flag, set when rmask and wmask are both nonzero at capture.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY, RESP.
REQ-013 In IDLE, at an edge with rmask or wmask nonzero, SHALL capture addr, wdata and the operation, and go to BUSY with count = LATENCY-1 (LATENCY=1: go directly to RESP).
REQ-014 In IDLE with no request, SHALL remain in IDLE.
REQ-015 In BUSY, SHALL decrement count each edge and go to RESP at the edge where count equals 1.
REQ-016 SHALL assert resp high for exactly the one cycle spent in RESP.
REQ-017 If capture occurs at edge E0, SHALL make resp high during the cycle following edge E0+LATENCY-1.
REQ-018 RESP SHALL always return to IDLE at the next edge, with no capture on that edge.
REQ-019 Consequence of REQ-018: earliest next capture is the edge after the RESP cycle, so a request held high through resp is not double-served.
REQ-020 SHALL ignore changes to addr, rmask, wmask and wdata while in BUSY or RESP; the captured values are used.
REQ-021 Write: SHALL update array[index] with captured wdata at the edge entering RESP; rdata unchanged.
REQ-022 Read: SHALL load rdata from array[index] at the edge entering RESP; rdata held until the next read response.
REQ-023 A read captured after a write response to the same index SHALL return the written data.
REQ-024 If both masks are nonzero at capture, SHALL perform the write only and set err.
REQ-025 err SHALL clear only on reset.

Reset
REQ-026 Asserting rst low SHALL asynchronously force state=IDLE, count=0, resp=0, rdata=0, err=0, and all array lines to 0.
REQ-027 Reset mid-operation SHALL abandon the pending request: no resp and no array write.
REQ-028 Deassertion SHALL take effect at the next clk edge; a request present at that edge SHALL be captured.

Structure
REQ-029 Package line_mem_pkg SHALL hold LINE_W=256, ADDR_W=32, OFFSET_W=5, and the state enum typedef.
REQ-030 Storage SHALL be sub-module line_mem_array (DEPTH x 256, synchronous write, registered read port, async clear).
REQ-031 The FSM, counter and capture registers SHALL live in line_mem_responder.

Verification
REQ-032 Bench SHALL cover: reset, then a read of addr 0x40 with LATENCY=4 -> resp exactly 4 cycles after capture, rdata=0.
REQ-033 Bench SHALL cover: write 0xA5-repeated line to 0x60, then a read of 0x60 -> rdata=0xA5..A5; a read of 0x80 -> rdata=0.
REQ-034 Bench SHALL cover: read held high through resp -> exactly one resp pulse; the next resp comes no earlier than 5 cycles later (REQ-019).
REQ-035 Bench SHALL cover: rmask=4'hF and wmask=4'hF at 0x20 -> write performed, err=1 and remaining 1 until reset.
REQ-036 Bench SHALL cover: rst low during BUSY of a write to 0x20 -> no resp; a later read of 0x20 -> rdata=0.
REQ-037 Bench SHALL cover: LATENCY=1 with DEPTH=16, write to 0x200 (aliases index 0), then a read of 0x0 -> resp the cycle after capture and rdata returns the written line.
